// File: rtl/result_frame_tx_pkg.sv
// Shared types and constants for the result framer: record layout, frame
// lengths, FSM encoding and the byte-select helper.
package result_frame_tx_pkg;

  localparam logic [7:0] SYNC0_DEF       = 8'hA5;
  localparam logic [7:0] SYNC1_DEF       = 8'h5A;
  localparam int         FRAME_LEN_CHK   = 14;
  localparam int         FRAME_LEN_NOCHK = 13;
  localparam int         RESULT_W        = 88;

  // One scan result as produced by the packet processor (8 + 5*16 bits).
  typedef struct packed {
    logic [7:0]  ct;
    logic [15:0] fsa;
    logic [15:0] lsa;
    logic [15:0] alert;
    logic [15:0] maxa;
    logic [15:0] mina;
  } result_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Frame byte at position idx; 16-bit fields go out little-endian.
  function automatic logic [7:0] frame_byte(input result_t r, input logic [3:0] idx,
                                            input logic [7:0] s0, input logic [7:0] s1,
                                            input logic [7:0] chk);
    logic [7:0] b;
    b = 8'h00;
    case (idx)
      4'd0:    b = s0;
      4'd1:    b = s1;
      4'd2:    b = r.ct;
      4'd3:    b = r.fsa[7:0];
      4'd4:    b = r.fsa[15:8];
      4'd5:    b = r.lsa[7:0];
      4'd6:    b = r.lsa[15:8];
      4'd7:    b = r.alert[7:0];
      4'd8:    b = r.alert[15:8];
      4'd9:    b = r.maxa[7:0];
      4'd10:   b = r.maxa[15:8];
      4'd11:   b = r.mina[7:0];
      4'd12:   b = r.mina[15:8];
      4'd13:   b = chk;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/result_frame_tx_if.sv
// Result input and byte-stream output bundle of the framer.
interface result_frame_tx_if;
  logic        rx_dv;
  logic [7:0]  s_CT;
  logic [15:0] s_FSA;
  logic [15:0] s_LSA;
  logic [15:0] obs_alert;
  logic [15:0] max_dist_angle;
  logic [15:0] min_dist_angle;
  logic        tx_ready;
  logic        tx_valid;
  logic [7:0]  tx_byte;

  // Producer of results / consumer of bytes.
  modport master (
    output rx_dv, s_CT, s_FSA, s_LSA, obs_alert, max_dist_angle, min_dist_angle, tx_ready,
    input  tx_valid, tx_byte
  );

  // The framer itself.
  modport slave (
    input  rx_dv, s_CT, s_FSA, s_LSA, obs_alert, max_dist_angle, min_dist_angle, tx_ready,
    output tx_valid, tx_byte
  );
endinterface

// File: rtl/result_frame_tx_result_slot.sv
// One result record register with a valid flag; used for snapshot and pending.
module result_slot
  import result_frame_tx_pkg::*;
(
  input  logic    clk,
  input  logic    reset_n,
  input  logic    load_i,
  input  logic    clear_i,
  input  result_t d_i,
  output result_t q_o,
  output logic    valid_o
);

  result_t data_q;
  logic    valid_q;

  // Load wins over clear so a promote-and-refill in one cycle keeps the slot full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (load_i) begin
      data_q  <= d_i;
      valid_q <= 1'b1;
    end else if (clear_i) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end
  end

  assign q_o     = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/result_frame_tx.sv
// Scan-result framer: snapshots a result on rx_dv, serialises it as a
// sync-prefixed little-endian byte frame with optional checksum, and
// buffers one further result while a frame is in flight.
module result_frame_tx
  import result_frame_tx_pkg::*;
#(
  parameter logic [7:0] SYNC0  = SYNC0_DEF,
  parameter logic [7:0] SYNC1  = SYNC1_DEF,
  parameter bit         CHK_EN = 1'b1
) (
  input  logic                clk,
  input  logic                reset_n,
  result_frame_tx_if.slave    bus,
  output logic                busy,
  output logic                frame_done,
  output logic                overrun
);

  localparam int         FLEN     = CHK_EN ? FRAME_LEN_CHK : FRAME_LEN_NOCHK;
  localparam logic [3:0] LAST_IDX = 4'(FLEN - 1);

  state_t     state_q, state_d;
  logic [3:0] idx_q, idx_d;
  logic [7:0] chk_q, chk_d;
  logic       ovr_q, ovr_d;

  result_t    in_res, snap_q, pend_q, snap_src;
  logic       snap_ld, snap_clr, snap_vld;
  logic       pend_ld, pend_clr, pend_full;
  logic [7:0] byte_c;
  logic       xfer;

  assign in_res = '{ct:    bus.s_CT,      fsa:  bus.s_FSA,          lsa:  bus.s_LSA,
                    alert: bus.obs_alert, maxa: bus.max_dist_angle, mina: bus.min_dist_angle};

  result_slot u_snap (
    .clk(clk), .reset_n(reset_n), .load_i(snap_ld), .clear_i(snap_clr),
    .d_i(snap_src), .q_o(snap_q), .valid_o(snap_vld)
  );

  result_slot u_pend (
    .clk(clk), .reset_n(reset_n), .load_i(pend_ld), .clear_i(pend_clr),
    .d_i(in_res), .q_o(pend_q), .valid_o(pend_full)
  );

  assign byte_c       = frame_byte(snap_q, idx_q, SYNC0, SYNC1, chk_q);
  assign bus.tx_valid = (state_q == ST_SEND) && snap_vld;
  assign bus.tx_byte  = (state_q == ST_SEND) ? byte_c : 8'h00;
  assign xfer         = bus.tx_valid && bus.tx_ready;

  assign busy       = (state_q != ST_IDLE) || pend_full;
  assign frame_done = (state_q == ST_DONE);
  assign overrun    = ovr_q;

  // State, byte index, running checksum and sticky overrun flag.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      idx_q   <= 4'd0;
      chk_q   <= 8'h00;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      chk_q   <= chk_d;
      ovr_q   <= ovr_d;
    end
  end

  // Next-state, slot control and checksum accumulation.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    chk_d    = chk_q;
    ovr_d    = ovr_q;
    snap_ld  = 1'b0;
    snap_clr = 1'b0;
    snap_src = in_res;
    pend_ld  = 1'b0;
    pend_clr = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.rx_dv) begin
          snap_ld = 1'b1;
          idx_d   = 4'd0;
          chk_d   = 8'h00;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        if (xfer) begin
          idx_d = idx_q + 4'd1;
          // Only payload bytes count; sync and the checksum byte itself do not.
          if (idx_q >= 4'd2 && idx_q <= 4'd12) chk_d = chk_q + byte_c;
          if (idx_q == LAST_IDX) state_d = ST_DONE;
        end
        if (bus.rx_dv) begin
          if (!pend_full) pend_ld = 1'b1;
          else            ovr_d   = 1'b1;
        end
      end
      ST_DONE: begin
        idx_d = 4'd0;
        chk_d = 8'h00;
        if (pend_full) begin
          // Promote pending; a result arriving now refills the slot in the same edge.
          snap_ld  = 1'b1;
          snap_src = pend_q;
          state_d  = ST_SEND;
          if (bus.rx_dv) pend_ld  = 1'b1;
          else           pend_clr = 1'b1;
        end else if (bus.rx_dv) begin
          // Nothing queued: start the new result directly rather than parking it.
          snap_ld = 1'b1;
          state_d = ST_SEND;
        end else begin
          snap_clr = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_result_frame_tx.sv
// Directed bench for result_frame_tx: nominal frame, stalled sink, pending
// result, dropped result, mid-frame reset and the no-checksum variant.
module tb_result_frame_tx;
  import result_frame_tx_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic busy_a, done_a, ovr_a;
  logic busy_b, done_b, ovr_b;

  int errors = 0;
  int checks = 0;

  logic [7:0] got [0:15];
  int         got_n;
  result_t    r1, r2, r3, r6, inj_r1, inj_r2;

  result_frame_tx_if a ();
  result_frame_tx_if b ();

  result_frame_tx #(.CHK_EN(1'b1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(a.slave),
    .busy(busy_a), .frame_done(done_a), .overrun(ovr_a)
  );

  result_frame_tx #(.CHK_EN(1'b0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(b.slave),
    .busy(busy_b), .frame_done(done_b), .overrun(ovr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference frame: sync, little-endian fields, sum of payload bytes.
  function automatic logic [7:0] eb(input result_t r, input int i);
    logic [7:0] f [0:13];
    logic [7:0] s;
    f[0] = 8'hA5;          f[1] = 8'h5A;          f[2] = r.ct;
    f[3] = r.fsa[7:0];     f[4] = r.fsa[15:8];
    f[5] = r.lsa[7:0];     f[6] = r.lsa[15:8];
    f[7] = r.alert[7:0];   f[8] = r.alert[15:8];
    f[9] = r.maxa[7:0];    f[10] = r.maxa[15:8];
    f[11] = r.mina[7:0];   f[12] = r.mina[15:8];
    s = 8'h00;
    for (int j = 2; j < 13; j++) s = s + f[j];
    f[13] = s;
    return f[i];
  endfunction

  task automatic drive(input result_t r, input bit use_b);
    if (use_b) begin
      b.s_CT = r.ct; b.s_FSA = r.fsa; b.s_LSA = r.lsa;
      b.obs_alert = r.alert; b.max_dist_angle = r.maxa; b.min_dist_angle = r.mina;
    end else begin
      a.s_CT = r.ct; a.s_FSA = r.fsa; a.s_LSA = r.lsa;
      a.obs_alert = r.alert; a.max_dist_angle = r.maxa; a.min_dist_angle = r.mina;
    end
  endtask

  // Pulse rx_dv for one edge; SYNC0 must be presented the very next cycle.
  task automatic start(input result_t r, input bit use_b);
    drive(r, use_b);
    if (use_b) b.rx_dv = 1'b1; else a.rx_dv = 1'b1;
    @(negedge clk);
    a.rx_dv = 1'b0;
    b.rx_dv = 1'b0;
    chk("lat_valid", 32'(use_b ? b.tx_valid : a.tx_valid), 32'd1);
    chk("lat_sync0", 32'(use_b ? b.tx_byte : a.tx_byte), 32'hA5);
  endtask

  // Collect nbytes transfers starting at a negedge; optional 1,0,0 ready
  // pattern with hold checks, and optional rx_dv injections (on bus a).
  task automatic recv(input int nbytes, input bit use_b, input bit stall,
                      input int inj1, input int inj2);
    bit held_v, d1, d2, rdy, v;
    logic [7:0] held, by;
    got_n = 0; held_v = 1'b0; d1 = 1'b0; d2 = 1'b0; held = 8'h00;
    for (int k = 0; k < 400 && got_n < nbytes; k++) begin
      rdy = stall ? (k % 3 == 0) : 1'b1;
      if (use_b) b.tx_ready = rdy; else a.tx_ready = rdy;
      a.rx_dv = 1'b0;
      if (inj1 >= 0 && !d1 && got_n == inj1) begin
        drive(inj_r1, 1'b0); a.rx_dv = 1'b1; d1 = 1'b1;
      end else if (inj2 >= 0 && !d2 && got_n == inj2) begin
        drive(inj_r2, 1'b0); a.rx_dv = 1'b1; d2 = 1'b1;
      end
      v  = use_b ? b.tx_valid : a.tx_valid;
      by = use_b ? b.tx_byte  : a.tx_byte;
      if (held_v) begin
        chk("stall_valid", 32'(v), 32'd1);
        chk("stall_hold", 32'(by), 32'(held));
      end
      held_v = 1'b0;
      if (v && rdy) begin
        got[got_n] = by;
        got_n++;
      end else if (v) begin
        held_v = 1'b1;
        held   = by;
      end
      @(negedge clk);
    end
    a.rx_dv = 1'b0;
    if (use_b) b.tx_ready = 1'b1; else a.tx_ready = 1'b1;
    chk("frame_len", 32'(got_n), 32'(nbytes));
  endtask

  task automatic cmp_frame(input string tag, input result_t r, input int n);
    for (int i = 0; i < n && i < got_n; i++)
      chk($sformatf("%s[%0d]", tag, i), 32'(got[i]), 32'(eb(r, i)));
  endtask

  initial begin
    r1 = '{ct: 8'h10, fsa: 16'h1234, lsa: 16'h5678, alert: 16'h00F0, maxa: 16'h2000, mina: 16'h3000};
    r2 = '{ct: 8'h01, fsa: 16'h0201, lsa: 16'h0403, alert: 16'h0605, maxa: 16'h0807, mina: 16'h0A09};
    r3 = '{ct: 8'hEE, fsa: 16'hDEAD, lsa: 16'hBEEF, alert: 16'hCAFE, maxa: 16'hF00D, mina: 16'h1357};
    r6 = '{ct: 8'hFF, fsa: 16'hFFFF, lsa: 16'hFFFF, alert: 16'hFFFF, maxa: 16'hFFFF, mina: 16'hFFFF};
    inj_r1 = r2; inj_r2 = r3;
    a.rx_dv = 1'b0; a.tx_ready = 1'b1; drive('0, 1'b0);
    b.rx_dv = 1'b0; b.tx_ready = 1'b1; drive('0, 1'b1);

    // Reset state
    #1;
    chk("rst_valid", 32'(a.tx_valid), 32'd0);
    chk("rst_byte", 32'(a.tx_byte), 32'h00);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_ovr", 32'(ovr_a), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: back-to-back bytes with ready held high
    start(r1, 1'b0);
    recv(14, 1'b0, 1'b0, -1, -1);
    cmp_frame("t1", r1, 14);
    chk("t1_chk_hand", 32'(got[13]), 32'h64);   // 10+34+12+78+56+F0+00+00+20+00+30 = 0x264
    chk("t1_done", 32'(done_a), 32'd1);
    chk("t1_done_valid", 32'(a.tx_valid), 32'd0);
    chk("t1_done_busy", 32'(busy_a), 32'd1);
    @(negedge clk);
    chk("t1_done_pulse", 32'(done_a), 32'd0);
    chk("t1_idle_busy", 32'(busy_a), 32'd0);

    // 2: stalled sink, byte held while tx_ready low
    start(r1, 1'b0);
    recv(14, 1'b0, 1'b1, -1, -1);
    cmp_frame("t2", r1, 14);
    chk("t2_done", 32'(done_a), 32'd1);
    @(negedge clk);

    // 3: second result during frame 1 is queued and follows after one gap cycle
    start(r1, 1'b0);
    recv(14, 1'b0, 1'b0, 5, -1);
    cmp_frame("t3_f1", r1, 14);
    chk("t3_done", 32'(done_a), 32'd1);
    chk("t3_busy_done", 32'(busy_a), 32'd1);
    chk("t3_gap_valid", 32'(a.tx_valid), 32'd0);
    @(negedge clk);
    chk("t3_f2_valid", 32'(a.tx_valid), 32'd1);
    chk("t3_f2_sync0", 32'(a.tx_byte), 32'hA5);
    chk("t3_busy_f2", 32'(busy_a), 32'd1);
    recv(14, 1'b0, 1'b0, -1, -1);
    cmp_frame("t3_f2", r2, 14);
    chk("t3_f2_chk_hand", 32'(got[13]), 32'h38);
    chk("t3_ovr", 32'(ovr_a), 32'd0);
    @(negedge clk);
    chk("t3_idle_busy", 32'(busy_a), 32'd0);

    // 4: third result with pending full is dropped, overrun sticks
    start(r1, 1'b0);
    recv(14, 1'b0, 1'b0, 3, 8);
    cmp_frame("t4_f1", r1, 14);
    chk("t4_ovr_f1", 32'(ovr_a), 32'd1);
    @(negedge clk);
    chk("t4_f2_sync0", 32'(a.tx_byte), 32'hA5);
    recv(14, 1'b0, 1'b0, -1, -1);
    cmp_frame("t4_f2", r2, 14);
    chk("t4_done", 32'(done_a), 32'd1);
    @(negedge clk);
    chk("t4_no_f3", 32'(a.tx_valid), 32'd0);
    chk("t4_idle_busy", 32'(busy_a), 32'd0);
    chk("t4_ovr_sticky", 32'(ovr_a), 32'd1);

    // 5: reset at byte 7 abandons the frame asynchronously
    start(r1, 1'b0);
    recv(7, 1'b0, 1'b0, 5, -1);
    cmp_frame("t5", r1, 7);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(a.tx_valid), 32'd0);
    chk("t5_async_busy", 32'(busy_a), 32'd0);
    chk("t5_async_byte", 32'(a.tx_byte), 32'h00);
    chk("t5_ovr_clr", 32'(ovr_a), 32'd0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;
    begin
      int seen;
      seen = 0;
      for (int k = 0; k < 6; k++) begin
        @(negedge clk);
        if (a.tx_valid || busy_a) seen++;
      end
      chk("t5_no_resume", 32'(seen), 32'd0);
    end

    // 6: no-checksum variant, 13-byte frame
    start(r6, 1'b1);
    recv(13, 1'b1, 1'b0, -1, -1);
    cmp_frame("t6", r6, 13);
    chk("t6_done", 32'(done_b), 32'd1);
    chk("t6_no_chk_byte", 32'(b.tx_valid), 32'd0);
    @(negedge clk);
    chk("t6_idle_valid", 32'(b.tx_valid), 32'd0);
    chk("t6_idle_busy", 32'(busy_b), 32'd0);
    chk("t6_a_quiet", 32'(a.tx_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
